// File: rtl/hv_pulse_pkg.sv
// Shared state encoding for the HV pulse sequencer.
package hv_pulse_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_ON     = 3'd2;
    localparam logic [2:0] ST_OFF    = 3'd3;
    localparam logic [2:0] ST_COOL   = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        ON     = ST_ON,
        OFF    = ST_OFF,
        COOL   = ST_COOL,
        FAULT  = ST_FAULT
    } hv_pulse_state_t;

endpackage

// File: rtl/hv_interval_timer.sv
// Prescaled interval timer: expire pulses after max(length,1)*(prescale+1) clk
// counted from the last restart.
module hv_interval_timer #(
    parameter int PRESCALE_WIDTH = 16,
    parameter int WIDTH          = 16
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      restart,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          length,
    output logic                      expire
);

    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [WIDTH-1:0]          tick_cnt;
    logic [WIDTH-1:0]          last_tick;
    logic                      tick;

    // A zero length behaves as one tick.
    assign last_tick = (length == '0) ? '0 : length - 1'b1;
    assign tick      = (presc_cnt == prescale);
    assign expire    = tick && (tick_cnt == last_tick);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            presc_cnt <= '0;
            tick_cnt  <= '0;
        end else if (restart) begin
            presc_cnt <= '0;
            tick_cnt  <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            tick_cnt  <= (tick_cnt == last_tick) ? '0 : tick_cnt + 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hv_pulse_ctrl.sv
// Wire-EDM HV sequencer: supply on, settle, gap pulse train, short cool-down
// and latched fault shutdown. All outputs are decoded from the next state.
module hv_pulse_ctrl
    import hv_pulse_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16,
    parameter int WIDTH          = 16
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      sclr,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      fault_clr,
    input  logic                      fault_in,
    input  logic                      short_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          t_settle,
    input  logic [WIDTH-1:0]          t_on,
    input  logic [WIDTH-1:0]          t_off,
    input  logic [WIDTH-1:0]          t_short,
    output logic                      hv_out,
    output logic                      permit,
    output logic                      pulse,
    output logic                      busy,
    output logic                      fault,
    output logic [WIDTH-1:0]          pulse_cnt
);

    hv_pulse_state_t state, state_nxt;
    logic [1:0]       fault_sync, short_sync;
    logic             fault_s, short_s;
    logic [WIDTH-1:0] interval;
    logic             expire, restart, retrig;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            fault_sync <= '0;
            short_sync <= '0;
        end else if (sclr) begin
            fault_sync <= '0;
            short_sync <= '0;
        end else begin
            fault_sync <= {fault_sync[0], fault_in};
            short_sync <= {short_sync[0], short_in};
        end
    end

    assign fault_s = fault_sync[1];
    assign short_s = short_sync[1];

    always_comb begin
        interval = '0;
        case (state)
            SETTLE:  interval = t_settle;
            ON:      interval = t_on;
            OFF:     interval = t_off;
            COOL:    interval = t_short;
            default: interval = '0;
        endcase
    end

    hv_interval_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .WIDTH         (WIDTH)
    ) u_timer (
        .clk     (clk),
        .aclr    (aclr),
        .restart (restart),
        .prescale(prescale),
        .length  (interval),
        .expire  (expire)
    );

    always_comb begin
        state_nxt = state;
        retrig    = 1'b0;
        if (fault_s) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = SETTLE;
                SETTLE:  if (stop) state_nxt = IDLE;
                         else if (expire) state_nxt = ON;
                ON:      if (stop) state_nxt = IDLE;
                         else if (short_s) state_nxt = COOL;
                         else if (expire) state_nxt = OFF;
                OFF:     if (stop) state_nxt = IDLE;
                         else if (expire) state_nxt = ON;
                // A short still present at expiry re-arms the cool-down.
                COOL:    if (stop) state_nxt = IDLE;
                         else if (expire) begin
                             if (short_s) retrig = 1'b1;
                             else state_nxt = ON;
                         end
                FAULT:   if (fault_clr) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign restart = (state_nxt != state) || retrig;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            hv_out    <= 1'b0;
            permit    <= 1'b0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            pulse_cnt <= '0;
        end else if (sclr) begin
            state     <= IDLE;
            hv_out    <= 1'b0;
            permit    <= 1'b0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state  <= state_nxt;
            hv_out <= state_nxt inside {SETTLE, ON, OFF, COOL};
            permit <= state_nxt inside {ON, OFF, COOL};
            pulse  <= (state_nxt == ON);
            busy   <= (state_nxt != IDLE);
            fault  <= (state_nxt == FAULT);
            if (state == IDLE && state_nxt == SETTLE)
                pulse_cnt <= '0;
            else if (state_nxt == ON && state != ON)
                pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hv_pulse_ctrl.sv
// Bench for hv_pulse_ctrl: directed scenarios plus random traffic, all checked
// against a state/elapsed-time reference model.
module tb_hv_pulse_ctrl;

    localparam int PW = 8;
    localparam int W  = 6;

    localparam int S_IDLE = 0, S_SETTLE = 1, S_ON = 2, S_OFF = 3, S_COOL = 4, S_FAULT = 5;

    logic          clk = 1'b0;
    logic          aclr, sclr, start, stop, fault_clr, fault_in, short_in;
    logic [PW-1:0] prescale;
    logic [W-1:0]  t_settle, t_on, t_off, t_short;
    logic          hv_out, permit, pulse, busy, fault;
    logic [W-1:0]  pulse_cnt;

    int checks   = 0;
    int failures = 0;

    int           m_st, m_el;
    logic [W-1:0] m_cnt;
    logic [1:0]   m_f, m_s;

    hv_pulse_ctrl #(.PRESCALE_WIDTH(PW), .WIDTH(W)) dut (
        .clk(clk), .aclr(aclr), .sclr(sclr), .start(start), .stop(stop),
        .fault_clr(fault_clr), .fault_in(fault_in), .short_in(short_in),
        .prescale(prescale), .t_settle(t_settle), .t_on(t_on), .t_off(t_off),
        .t_short(t_short), .hv_out(hv_out), .permit(permit), .pulse(pulse),
        .busy(busy), .fault(fault), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Duration of a state in clk cycles for the current settings.
    function automatic int dur(input int st);
        int n;
        case (st)
            S_SETTLE: n = int'(t_settle);
            S_ON:     n = int'(t_on);
            S_OFF:    n = int'(t_off);
            S_COOL:   n = int'(t_short);
            default:  n = 1;
        endcase
        if (n == 0) n = 1;
        return n * (int'(prescale) + 1);
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_el = 0; m_cnt = '0; m_f = '0; m_s = '0;
    endtask

    task automatic model_edge();
        int nxt;
        bit ex, rt, fs, ss;
        if (sclr) begin
            model_reset();
            return;
        end
        fs  = m_f[1];
        ss  = m_s[1];
        ex  = (m_el + 1 >= dur(m_st));
        rt  = 1'b0;
        nxt = m_st;
        if (fs) nxt = S_FAULT;
        else if (m_st == S_IDLE) begin if (start) nxt = S_SETTLE; end
        else if (m_st == S_FAULT) begin if (fault_clr) nxt = S_IDLE; end
        else if (stop) nxt = S_IDLE;
        else if (m_st == S_ON && ss) nxt = S_COOL;
        else if (ex) begin
            case (m_st)
                S_SETTLE: nxt = S_ON;
                S_ON:     nxt = S_OFF;
                S_OFF:    nxt = S_ON;
                default:  if (ss) rt = 1'b1; else nxt = S_ON;
            endcase
        end
        if (m_st == S_IDLE && nxt == S_SETTLE) m_cnt = '0;
        if (nxt == S_ON && m_st != S_ON) m_cnt = m_cnt + 1'b1;
        m_el = (nxt != m_st || rt) ? 0 : m_el + 1;
        m_st = nxt;
        m_f  = {m_f[0], fault_in};
        m_s  = {m_s[0], short_in};
    endtask

    task automatic compare();
        logic [4:0] ef;
        ef[4] = (m_st == S_SETTLE || m_st == S_ON || m_st == S_OFF || m_st == S_COOL);
        ef[3] = (m_st == S_ON || m_st == S_OFF || m_st == S_COOL);
        ef[2] = (m_st == S_ON);
        ef[1] = (m_st != S_IDLE);
        ef[0] = (m_st == S_FAULT);
        chk("flags{hv,permit,pulse,busy,fault}", 32'({hv_out, permit, pulse, busy, fault}), 32'(ef));
        chk("pulse_cnt", 32'(pulse_cnt), 32'(m_cnt));
    endtask

    // Inputs are driven at the falling edge; one rising edge, then compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        start = 0; stop = 0; fault_clr = 0; sclr = 0;
        compare();
    endtask

    task automatic wait_pulse(input logic lvl);
        int n = 0;
        while (pulse !== lvl && n < 300) begin step(); n++; end
        chk("wait_pulse", 32'(pulse), 32'(lvl));
    endtask

    task automatic set_cfg(input int p, input int s, input int on, input int off, input int sh);
        prescale = PW'(p); t_settle = W'(s); t_on = W'(on); t_off = W'(off); t_short = W'(sh);
    endtask

    initial begin
        int n;
        logic [W-1:0] held;
        aclr = 1; sclr = 0; start = 0; stop = 0; fault_clr = 0; fault_in = 0; short_in = 0;
        set_cfg(3, 2, 1, 2, 2);
        model_reset();
        #12;
        compare();
        @(negedge clk);
        aclr = 0;
        step();

        // Basic run
        start = 1; step();
        n = 0;
        while (!pulse && n < 50) begin n += int'(hv_out); step(); end
        chk("settle_len", 32'(n), 32'd8);
        n = 0;
        while (pulse && n < 50) begin n++; step(); end
        chk("pulse_high_len", 32'(n), 32'd4);
        n = 0;
        while (!pulse && n < 50) begin n++; step(); end
        chk("pulse_low_len", 32'(n), 32'd8);
        wait_pulse(1'b0);
        wait_pulse(1'b1);
        chk("cnt_third_rise", 32'(pulse_cnt), 32'd3);
        stop = 1; step();

        // Zero values: one clk per state, then counter wrap
        set_cfg(0, 0, 0, 0, 0);
        start = 1; step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("zero_toggle", 32'(pulse), 32'((i % 2) == 0));
        end
        n = 0;
        while (!(pulse && pulse_cnt == W'(2**W - 1)) && n < 300) begin step(); n++; end
        step(); step();
        chk("cnt_wrap", 32'(pulse_cnt), 32'd0);
        stop = 1; step();

        // Short during ON
        set_cfg(0, 1, 40, 1, 2);
        start = 1; step();
        wait_pulse(1'b1);
        short_in = 1;
        step(); step();
        chk("short_pulse_k1", 32'(pulse), 32'd1);
        step();
        chk("short_pulse_k2", 32'(pulse), 32'd0);
        repeat (17) step();
        chk("cool_holds", 32'({permit, pulse}), 32'b10);
        short_in = 0;
        wait_pulse(1'b1);
        stop = 1; step();

        // Fault during ON
        start = 1; step();
        wait_pulse(1'b1);
        fault_in = 1;
        step(); step(); step();
        chk("fault_hv_fault", 32'({hv_out, fault}), 32'b01);
        start = 1; step();
        fault_clr = 1; step();
        chk("fault_clr_ignored", 32'(fault), 32'd1);
        fault_in = 0;
        repeat (3) step();
        fault_clr = 1; step();
        chk("fault_cleared", 32'({busy, fault}), 32'b00);

        // Stop on the same edge as t_on expiry
        set_cfg(0, 1, 3, 3, 2);
        start = 1; step();
        wait_pulse(1'b1);
        n = 0;
        while (!(m_st == S_ON && m_el + 1 == dur(S_ON)) && n < 50) begin step(); n++; end
        held = pulse_cnt;
        stop = 1; step();
        chk("stop_prio", 32'({busy, pulse}), 32'b00);
        chk("stop_cnt_held", 32'(pulse_cnt), 32'(held));

        // aclr in COOL
        set_cfg(0, 1, 40, 1, 10);
        start = 1; step();
        wait_pulse(1'b1);
        short_in = 1;
        step(); step(); step();
        short_in = 0;
        #2 aclr = 1;
        #1 model_reset();
        compare();
        chk("aclr_async", 32'({hv_out, permit, pulse, busy, fault}), 32'd0);
        @(negedge clk);
        aclr = 0;
        compare();

        // sclr in FAULT
        fault_in = 1;
        step(); step(); step();
        chk("in_fault", 32'(fault), 32'd1);
        fault_in = 0;
        sclr = 1; step();
        chk("sclr_fault", 32'({busy, fault, pulse_cnt}), 32'd0);
        start = 1; step();
        step();
        chk("latch_cleared", 32'({busy, fault}), 32'b10);
        stop = 1; step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (m_st == S_IDLE && $urandom_range(0, 7) == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5),
                        $urandom_range(0, 5), $urandom_range(0, 4));
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 49) == 0);
            fault_clr = ($urandom_range(0, 5) == 0);
            sclr      = ($urandom_range(0, 399) == 0);
            if (fault_in) fault_in = ($urandom_range(0, 7) != 0);
            else          fault_in = ($urandom_range(0, 199) == 0);
            if (short_in) short_in = ($urandom_range(0, 5) != 0);
            else          short_in = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
